maxnet_ctrl: RTL



---
 rtl/maxnet_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/maxnet_ctrl.sv
// Sequencer for a 4-node winner-take-all PU array: LOAD, then S1/S2/CHECK per iteration with FEED between; done at k+5 for one iteration, +4 per extra.
// No backpressure: start is accepted only in IDLE and ignored otherwise; a_new is sampled only in CHECK.
module maxnet_ctrl #(
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       a_new0,
  input  logic [31:0]       a_new1,
  input  logic [31:0]       a_new2,
  input  logic [31:0]       a_new3,
  output logic              ld_en,
  output logic              init_sel,
  output logic              en1,
  output logic              en2,
  output logic              busy,
  output logic              done,
  output logic [1:0]        winner,
  output logic              no_winner,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    S1    = 3'd2,
    S2    = 3'd3,
    CHECK = 3'd4,
    FEED  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

  state_t      state, state_nxt;
  logic [3:0]  alive;
  logic [2:0]  alive_cnt;
  logic [1:0]  first_alive;

  // Sign bit ignored so that -0.0 counts as a dead node.
  assign alive[0] = (a_new0[30:0] != 31'd0);
  assign alive[1] = (a_new1[30:0] != 31'd0);
  assign alive[2] = (a_new2[30:0] != 31'd0);
  assign alive[3] = (a_new3[30:0] != 31'd0);

  assign alive_cnt = {2'b00, alive[0]} + {2'b00, alive[1]}
                   + {2'b00, alive[2]} + {2'b00, alive[3]};

  always_comb begin
    first_alive = 2'd0;
    if (alive[0])      first_alive = 2'd0;
    else if (alive[1]) first_alive = 2'd1;
    else if (alive[2]) first_alive = 2'd2;
    else if (alive[3]) first_alive = 2'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_en     = 1'b0;
    init_sel  = 1'b0;
    en1       = 1'b0;
    en2       = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_en     = 1'b1;
        init_sel  = 1'b1;
        state_nxt = S1;
      end
      S1: begin
        en1       = 1'b1;
        state_nxt = S2;
      end
      S2: begin
        en2       = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        // iter_count already includes this iteration here.
        if (alive_cnt <= 3'd1)            state_nxt = DONE;
        else if (iter_count == MAX_ITER_C) state_nxt = DONE;
        else                               state_nxt = FEED;
      end
      FEED: begin
        ld_en     = 1'b1;
        state_nxt = S1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_count <= '0;
      winner     <= 2'd0;
      no_winner  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        iter_count <= '0;
        winner     <= 2'd0;
        no_winner  <= 1'b0;
        timeout    <= 1'b0;
      end
      if (state == S2) begin
        iter_count <= iter_count + 1'b1;
      end
      if (state == CHECK && state_nxt == DONE) begin
        winner    <= first_alive;
        no_winner <= (alive_cnt == 3'd0);
        timeout   <= (alive_cnt > 3'd1);
      end
    end
  end

endmodule
